lector_bus_rtc: RTL and testbench
=================================

Name: lector_bus_rtc

Overview:
- Read-cycle sequencer for the RTC's multiplexed address/data parallel bus. It is the read-side counterpart of the existing write sequencer.
- Generates Cs_lectura plus the read-side RD, WR and A/D strobes. Cs_lectura feeds the chip-select mux, which the top level drives with En_Cs=0 during reads.
- Runs one timed register read per request: address phase, bus turnaround, data phase, capture, done pulse.

Parameters:
largo, 8, width of address/data bus and captured data
T_FASE, 4, clock cycles per bus phase (1..255)

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  asynchronous, active-high reset
iniciar  input  1  start request, sampled only in REPOSO
direccion  input  largo  RTC register address, latched on accepted start
bus_in  input  largo  data returned on AD bus (from top-level tristate)
bus_out  output  largo  value driven onto AD bus when bus_oe=1
bus_oe  output  1  AD bus output enable (1 = this block drives)
Cs_lectura  output  1  chip select, active low, to chip-select mux
Rd_lectura  output  1  read strobe, active low
Wr_lectura  output  1  write strobe used for address latch, active low
Ad_lectura  output  1  address/data select, 0 = address phase
dato_leido  output  largo  last captured register value
ocupado  output  1  1 while a read is in progress
listo  output  1  one-cycle pulse when dato_leido is updated

Behaviour:
- All outputs registered. Phase counter width is 8 bits.
- Reset (async, any time, including mid-cycle) forces:
  - state REPOSO, counter 0;
  - Cs/Rd/Wr/Ad = 1, bus_oe = 0, bus_out = 0;
  - dato_leido = 0, ocupado = 0, listo = 0.
- REPOSO: all strobes 1, bus_oe = 0, ocupado = 0.
  - iniciar=1 at an edge: latch direccion, go to A_SET, counter = 0, ocupado = 1 from the next cycle.
- Each state below except FIN lasts exactly T_FASE cycles. Counter counts 0..T_FASE-1, then advances state and clears.
  - A_SET: Ad=0, bus_oe=1, bus_out=latched address, Cs=Wr=Rd=1.
  - A_PULSO: Ad=0, bus_oe=1, Cs=0, Wr=0, Rd=1.
  - A_HOLD: Ad=0, bus_oe=1, Cs=1, Wr=1.
  - GIRO: Ad=1, bus_oe=0, all strobes 1 (bus turnaround; bus_out returns to 0).
  - D_PULSO: Ad=1, bus_oe=0, Cs=0, Rd=0.
    - On the edge ending the last cycle of D_PULSO (counter = T_FASE-1), dato_leido <= bus_in.
  - D_HOLD: Cs=1, Rd=1, Ad=1, bus_oe=0.
- FIN lasts one cycle: listo=1, ocupado=1, strobes idle. Then REPOSO (ocupado=0).
- Latency: with iniciar accepted at edge E, A_SET outputs appear after E. listo is high in the cycle following edge E+6*T_FASE. The next start is accepted at the earliest at edge E+6*T_FASE+2.
- iniciar while ocupado=1 is ignored, not queued. direccion changes after acceptance have no effect.
- Never Rd=0 and Wr=0 together. Never bus_oe=1 while Rd=0.
- Cs, Rd and Wr transitions occur only at phase boundaries, so there are no glitches.
- dato_leido holds its value between reads. It changes only at the capture edge or on reset.
- Reset during D_PULSO: no capture; dato_leido = 0.
- T_FASE=1: sequence collapses to 7 cycles, with identical ordering.

Test Plan:
- Reset then idle 20 cycles -> Cs/Rd/Wr/Ad=1, bus_oe=0, ocupado=0, listo=0, dato_leido=0x00.
- T_FASE=4, direccion=0x21, iniciar 1 cycle, bus model returns 0x59 while Rd=0 -> bus_out=0x21 with bus_oe=1 for 12 cycles. Then Wr=0 for 4 cycles within them. Then Rd=0 for 4 cycles. Then dato_leido=0x59, with listo high exactly 1 cycle, 25 cycles after the start edge.
- Hold iniciar=1 continuously, direccion alternating 0x22/0x23 -> back-to-back reads, each full 6*T_FASE+1 cycles. Each read uses the address present at its accept edge, and there is one idle REPOSO cycle between reads.
- Bus model changes bus_in from 0xAA to 0x55 one cycle before the end of D_PULSO -> dato_leido=0x55 (value at the last D_PULSO cycle only).
- Assert reset during A_PULSO and again during D_PULSO -> strobes return to 1 and bus_oe=0 immediately (asynchronously), listo never pulses, dato_leido=0x00. A fresh iniciar after release completes normally.
- Assertion monitor over a random start stream, T_FASE=1 and T_FASE=7 -> never Rd=0 and Wr=0 together, never bus_oe=1 while Rd=0, listo never 2 consecutive cycles.

Source files
------------

// File: rtl/lector_bus_rtc.sv
// -----------------------------------------------------------------------------
// lector_bus_rtc
//   Read-cycle sequencer for the RTC multiplexed address/data bus. A start
//   request runs one timed register read: address setup, address latch pulse
//   (Wr), address hold, bus turnaround, data pulse (Rd) with capture at its
//   last edge, data hold, then a one-cycle done pulse. Every phase except the
//   done cycle lasts T_FASE clocks. All outputs come straight from registers.
//
// Ports
//   clk         system clock, rising edge
//   reset       asynchronous, active-high reset
//   iniciar     start request, honoured only while idle
//   direccion   RTC register address, latched when a start is accepted
//   bus_in      data returned on the AD bus
//   bus_out     value driven onto the AD bus while bus_oe = 1
//   bus_oe      AD bus output enable (1 = this block drives)
//   Cs_lectura  chip select, active low
//   Rd_lectura  read strobe, active low
//   Wr_lectura  address latch strobe, active low
//   Ad_lectura  address/data select, 0 = address phase
//   dato_leido  last captured register value
//   ocupado     1 while a read is in progress
//   listo       one-cycle pulse when dato_leido has been updated
// -----------------------------------------------------------------------------
module lector_bus_rtc #(
    parameter int largo  = 8,
    parameter int T_FASE = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             iniciar,
    input  logic [largo-1:0] direccion,
    input  logic [largo-1:0] bus_in,
    output logic [largo-1:0] bus_out,
    output logic             bus_oe,
    output logic             Cs_lectura,
    output logic             Rd_lectura,
    output logic             Wr_lectura,
    output logic             Ad_lectura,
    output logic [largo-1:0] dato_leido,
    output logic             ocupado,
    output logic             listo
);

    typedef enum logic [2:0] {
        REPOSO,
        A_SET,
        A_PULSO,
        A_HOLD,
        GIRO,
        D_PULSO,
        D_HOLD,
        FIN
    } estado_t;

    localparam logic [7:0] CNT_ULTIMO = 8'(T_FASE - 1);

    estado_t          state_q, state_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [largo-1:0] addr_q, addr_d;
    logic [largo-1:0] dato_q, dato_d;
    logic [largo-1:0] bus_out_q, bus_out_d;
    logic             bus_oe_q, bus_oe_d;
    logic             cs_q, cs_d;
    logic             rd_q, rd_d;
    logic             wr_q, wr_d;
    logic             ad_q, ad_d;
    logic             ocupado_q, ocupado_d;
    logic             listo_q, listo_d;

    // Next state, then the outputs decoded from that next state so that the
    // registered outputs line up with the state they belong to.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it
        // unassigned; otherwise synthesis infers a latch to hold the old value.
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        dato_d    = dato_q;

        if (state_q == REPOSO) begin
            if (iniciar) begin
                state_d = A_SET;
                cnt_d   = '0;
                addr_d  = direccion;
            end
        end else if (state_q == FIN) begin
            state_d = REPOSO;
        end else if (cnt_q == CNT_ULTIMO) begin
            cnt_d = '0;
            case (state_q)
                A_SET:   state_d = A_PULSO;
                A_PULSO: state_d = A_HOLD;
                A_HOLD:  state_d = GIRO;
                GIRO:    state_d = D_PULSO;
                D_PULSO: begin
                    state_d = D_HOLD;
                    // Only the bus value at the final D_PULSO edge counts.
                    dato_d  = bus_in;
                end
                D_HOLD:  state_d = FIN;
                default: state_d = REPOSO;
            endcase
        end else begin
            cnt_d = cnt_q + 8'd1;
        end

        cs_d      = 1'b1;
        rd_d      = 1'b1;
        wr_d      = 1'b1;
        ad_d      = 1'b1;
        bus_oe_d  = 1'b0;
        bus_out_d = '0;
        ocupado_d = (state_d != REPOSO);
        listo_d   = (state_d == FIN);

        case (state_d)
            A_SET, A_HOLD: begin
                ad_d      = 1'b0;
                bus_oe_d  = 1'b1;
                bus_out_d = addr_d;
            end
            A_PULSO: begin
                ad_d      = 1'b0;
                bus_oe_d  = 1'b1;
                bus_out_d = addr_d;
                cs_d      = 1'b0;
                wr_d      = 1'b0;
            end
            D_PULSO: begin
                cs_d = 1'b0;
                rd_d = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (reset) begin
            state_q   <= REPOSO;
            cnt_q     <= '0;
            addr_q    <= '0;
            dato_q    <= '0;
            bus_out_q <= '0;
            bus_oe_q  <= 1'b0;
            cs_q      <= 1'b1;
            rd_q      <= 1'b1;
            wr_q      <= 1'b1;
            ad_q      <= 1'b1;
            ocupado_q <= 1'b0;
            listo_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            dato_q    <= dato_d;
            bus_out_q <= bus_out_d;
            bus_oe_q  <= bus_oe_d;
            cs_q      <= cs_d;
            rd_q      <= rd_d;
            wr_q      <= wr_d;
            ad_q      <= ad_d;
            ocupado_q <= ocupado_d;
            listo_q   <= listo_d;
        end
    end

    assign bus_out    = bus_out_q;
    assign bus_oe     = bus_oe_q;
    assign Cs_lectura = cs_q;
    assign Rd_lectura = rd_q;
    assign Wr_lectura = wr_q;
    assign Ad_lectura = ad_q;
    assign dato_leido = dato_q;
    assign ocupado    = ocupado_q;
    assign listo      = listo_q;

endmodule

// File: tb/tb_lector_bus_rtc.sv
// -----------------------------------------------------------------------------
// tb_lector_bus_rtc
//   Three instances (T_FASE = 4, 1, 7) share clock and reset. Each has a
//   cycle-index reference model: a read accepted at edge E is described by
//   k = edges since E, with phase = k / T_FASE, FIN at k = 6*T_FASE and
//   capture of bus_in at k = 5*T_FASE. The T_FASE=4 instance also runs the
//   directed scenarios; the others see random starts throughout.
// -----------------------------------------------------------------------------
module tb_lector_bus_rtc;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic       iniciar_w [3];
    logic [7:0] direccion_w [3];
    logic [7:0] bus_in_w [3];
    logic [7:0] bus_out_w [3];
    logic [7:0] dato_w [3];
    logic       oe_w [3], cs_w [3], rd_w [3], wr_w [3], ad_w [3], ocup_w [3], listo_w [3];

    int n_cmp = 0;
    int n_err = 0;

    // Directed-mode controls for instance 0.
    logic       rand0    = 1'b0;
    logic       ini_d0   = 1'b0;
    logic [7:0] dir_d0   = 8'h00;
    logic [7:0] bus_val0 = 8'h00;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Expected {Cs,Rd,Wr,Ad,oe,ocupado,listo,bus_out,dato} for read position k.
    function automatic logic [22:0] exp_outs(input bit busy, input int k, input int tf,
                                             input logic [7:0] a, input logic [7:0] d);
        int         ph;
        logic       cs, rd, wr, ad, oe, lst;
        logic [7:0] bo;
        ph  = busy ? ((k >= 6 * tf) ? 6 : k / tf) : 7;
        cs  = !(ph == 1 || ph == 4);
        wr  = (ph != 1);
        rd  = (ph != 4);
        ad  = (ph >= 3);
        oe  = (ph < 3);
        bo  = oe ? a : 8'h00;
        lst = (ph == 6);
        return {cs, rd, wr, ad, oe, busy, lst, bo, d};
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int TP = (g == 0) ? 4 : ((g == 1) ? 1 : 7);

        logic       ini_r = 1'b0;
        logic [7:0] dir_r = 8'h00;
        logic [7:0] bus_r = 8'h00;
        bit         busy = 1'b0;
        int         k = 0;
        logic [7:0] addr_m = 8'h00;
        logic [7:0] dato_m = 8'h00;
        logic       prev_listo = 1'b0;

        assign iniciar_w[g]   = (g == 0 && !rand0) ? ini_d0 : ini_r;
        assign direccion_w[g] = (g == 0 && !rand0) ? dir_d0 : dir_r;
        // Directed bus model: returns bus_val0 only while Rd is low.
        assign bus_in_w[g]    = (g == 0 && !rand0) ? (rd_w[0] ? 8'hFF : bus_val0) : bus_r;

        lector_bus_rtc #(.largo(8), .T_FASE(TP)) u_dut (
            .clk        (clk),
            .reset      (reset),
            .iniciar    (iniciar_w[g]),
            .direccion  (direccion_w[g]),
            .bus_in     (bus_in_w[g]),
            .bus_out    (bus_out_w[g]),
            .bus_oe     (oe_w[g]),
            .Cs_lectura (cs_w[g]),
            .Rd_lectura (rd_w[g]),
            .Wr_lectura (wr_w[g]),
            .Ad_lectura (ad_w[g]),
            .dato_leido (dato_w[g]),
            .ocupado    (ocup_w[g]),
            .listo      (listo_w[g])
        );

        always @(negedge clk) begin
            ini_r = ($urandom_range(0, 2) == 0);
            dir_r = 8'($urandom);
            bus_r = 8'($urandom);
        end

        always @(posedge clk or posedge reset) begin
            if (reset) begin
                busy   = 1'b0;
                k      = 0;
                dato_m = 8'h00;
            end else if (!busy) begin
                if (iniciar_w[g]) begin
                    busy   = 1'b1;
                    k      = 0;
                    addr_m = direccion_w[g];
                end
            end else begin
                k++;
                if (k == 5 * TP) dato_m = bus_in_w[g];
                if (k == 6 * TP + 1) busy = 1'b0;
            end
        end

        always @(negedge clk) begin
            check($sformatf("T%0d outputs", TP),
                  32'({cs_w[g], rd_w[g], wr_w[g], ad_w[g], oe_w[g], ocup_w[g], listo_w[g],
                       bus_out_w[g], dato_w[g]}),
                  32'(exp_outs(busy, k, TP, addr_m, dato_m)));
            check($sformatf("T%0d rd_wr_overlap", TP), 32'(rd_w[g] | wr_w[g]), 32'd1);
            check($sformatf("T%0d oe_while_rd", TP), 32'(oe_w[g] & ~rd_w[g]), 32'd0);
            check($sformatf("T%0d listo_twice", TP), 32'(prev_listo & listo_w[g]), 32'd0);
            prev_listo = listo_w[g];
        end
    end

    int oe_cnt, wr_lo, rd_lo, listo_cnt, listo_at;

    // Called at a negedge; sample n = 1 is the cycle right after the accept edge.
    task automatic observe(input int ncyc, input logic [7:0] addr,
                           input int sw_n, input logic [7:0] sw_val);
        oe_cnt = 0; wr_lo = 0; rd_lo = 0; listo_cnt = 0; listo_at = -1;
        for (int n = 1; n <= ncyc; n++) begin
            if (n == sw_n) bus_val0 = sw_val;
            if (oe_w[0] && bus_out_w[0] == addr) oe_cnt++;
            if (!wr_w[0]) wr_lo++;
            if (!rd_w[0]) rd_lo++;
            if (listo_w[0]) begin
                listo_cnt++;
                if (listo_at < 0) listo_at = n;
            end
            @(negedge clk);
        end
    endtask

    task automatic start_read(input logic [7:0] addr);
        ini_d0 = 1'b1;
        dir_d0 = addr;
        @(negedge clk);
        ini_d0 = 1'b0;
        dir_d0 = ~addr;
    endtask

    task automatic pulse_reset(input string tag);
        #1 reset = 1'b1;
        #1;
        check({tag, " async strobes"}, 32'({cs_w[0], rd_w[0], wr_w[0], ad_w[0]}), 32'hF);
        check({tag, " async oe/ocupado"}, 32'({oe_w[0], ocup_w[0]}), 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        check({tag, " dato after reset"}, 32'(dato_w[0]), 32'h00);
        observe(10, 8'h00, 0, 8'h00);
        check({tag, " no listo"}, 32'(listo_cnt), 32'd0);
    endtask

    initial begin
        int lt[$];
        reset = 1'b0;
        #1 reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        repeat (20) @(negedge clk);
        check("idle strobes", 32'({cs_w[0], rd_w[0], wr_w[0], ad_w[0]}), 32'hF);
        check("idle oe/ocupado/listo", 32'({oe_w[0], ocup_w[0], listo_w[0]}), 32'd0);
        check("idle dato", 32'(dato_w[0]), 32'h00);

        // Basic read: address 0x21, bus returns 0x59 while Rd is low.
        bus_val0 = 8'h59;
        start_read(8'h21);
        observe(30, 8'h21, 0, 8'h00);
        check("read oe cycles", 32'(oe_cnt), 32'd12);
        check("read wr low cycles", 32'(wr_lo), 32'd4);
        check("read rd low cycles", 32'(rd_lo), 32'd4);
        check("read listo count", 32'(listo_cnt), 32'd1);
        check("read listo position", 32'(listo_at), 32'd25);
        check("read dato", 32'(dato_w[0]), 32'h59);

        // Data changes one cycle before the end of D_PULSO.
        bus_val0 = 8'hAA;
        start_read(8'h40);
        observe(30, 8'h40, 20, 8'h55);
        check("late data dato", 32'(dato_w[0]), 32'h55);
        check("late data listo position", 32'(listo_at), 32'd25);

        // Back-to-back reads with iniciar held high.
        bus_val0 = 8'h5A;
        ini_d0   = 1'b1;
        for (int n = 1; n <= 90; n++) begin
            dir_d0 = ((n / 3) % 2 != 0) ? 8'h23 : 8'h22;
            if (listo_w[0]) lt.push_back(n);
            @(negedge clk);
        end
        ini_d0 = 1'b0;
        check("b2b listo count", 32'(lt.size()), 32'd3);
        if (lt.size() >= 3) begin
            check("b2b period 1", 32'(lt[1] - lt[0]), 32'd26);
            check("b2b period 2", 32'(lt[2] - lt[1]), 32'd26);
        end
        repeat (30) @(negedge clk);

        // Reset during A_PULSO.
        start_read(8'h44);
        observe(5, 8'h44, 0, 8'h00);
        check("in A_PULSO cs", 32'(cs_w[0]), 32'd0);
        pulse_reset("rst A_PULSO");

        // Load a nonzero value, then reset during D_PULSO.
        bus_val0 = 8'h9C;
        start_read(8'h31);
        observe(30, 8'h31, 0, 8'h00);
        check("pre D reset dato", 32'(dato_w[0]), 32'h9C);
        bus_val0 = 8'hAA;
        start_read(8'h32);
        observe(17, 8'h32, 0, 8'h00);
        check("in D_PULSO rd", 32'(rd_w[0]), 32'd0);
        pulse_reset("rst D_PULSO");

        // Fresh read after reset completes normally.
        bus_val0 = 8'h3C;
        start_read(8'h33);
        observe(30, 8'h33, 0, 8'h00);
        check("post reset listo count", 32'(listo_cnt), 32'd1);
        check("post reset listo position", 32'(listo_at), 32'd25);
        check("post reset dato", 32'(dato_w[0]), 32'h3C);

        // Random start stream on every instance.
        rand0 = 1'b1;
        repeat (600) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
